// File: rtl/crossbar_switch.sv
// crossbar_switch: eFPGA tile routing crossbar.
// Vertical tracks pass straight through. The horizontal outputs E_o/W_o are
// either default pass-throughs (W_i/E_i) or OR-combinations of the vertical
// inputs, selected by a 72-word configuration shift chain that cascades out
// through prog_o.
module crossbar_switch (
  input  logic        clk,
  input  logic        nres,
  input  logic [31:0] prog_i,
  input  logic        prog_shft,
  output logic [31:0] prog_o,
  input  logic [31:0] N_i,
  output logic [31:0] S_o,
  input  logic [15:0] S_i,
  output logic [15:0] N_o,
  input  logic [31:0] W_i,
  output logic [31:0] E_o,
  input  logic [15:0] E_i,
  output logic [15:0] W_o
);

  // Chain layout after a full load (first word shifted ends up in cfg[71]):
  //   cfg[71..56] SE block, cfg[55..48] SW block,
  //   cfg[47..16] NE block, cfg[15..0]  NW block.
  logic [31:0] cfg [0:71];

  // Configuration chain: reset clears everything and wins over shifting.
  always_ff @(posedge clk) begin
    if (nres) begin
      for (int i = 0; i < 72; i++) cfg[i] <= '0;
    end else if (prog_shft) begin
      cfg[0] <= prog_i;
      for (int i = 1; i < 72; i++) cfg[i] <= cfg[i-1];
    end
  end

  assign prog_o = cfg[71];

  // Vertical tracks are never reconfigured.
  assign S_o = N_i;
  assign N_o = S_i;

  // East outputs: NE word e is cfg[47-e]; SE word e/2 is cfg[71-e/2], with
  // even outputs using the low half and odd outputs the high half.
  for (genvar e = 0; e < 32; e++) begin : g_east
    logic [31:0] n_sel;
    logic [15:0] s_sel;
    logic        hit;
    assign n_sel  = cfg[47-e];
    assign s_sel  = (e % 2 == 1) ? cfg[71-e/2][31:16] : cfg[71-e/2][15:0];
    assign hit    = (|n_sel) | (|s_sel);
    assign E_o[e] = hit ? ((|(N_i & n_sel)) | (|(S_i & s_sel))) : W_i[e];
  end

  // West outputs: NW word o is cfg[15-o]; SW word o/2 is cfg[55-o/2], with
  // the same even/odd half split as the east side.
  for (genvar o = 0; o < 16; o++) begin : g_west
    logic [31:0] n_sel;
    logic [15:0] s_sel;
    logic        hit;
    assign n_sel  = cfg[15-o];
    assign s_sel  = (o % 2 == 1) ? cfg[55-o/2][31:16] : cfg[55-o/2][15:0];
    assign hit    = (|n_sel) | (|s_sel);
    assign W_o[o] = hit ? ((|(N_i & n_sel)) | (|(S_i & s_sel))) : E_i[o];
  end

endmodule

// File: tb/tb_crossbar_switch.sv
// Directed testbench for crossbar_switch.
module tb_crossbar_switch;

  logic        clk = 1'b0;
  logic        nres;
  logic [31:0] prog_i;
  logic        prog_shft;
  logic [31:0] prog_o;
  logic [31:0] N_i, S_o, W_i, E_o;
  logic [15:0] S_i, N_o, E_i, W_o;

  int checks = 0;
  int fails  = 0;

  // Words in shift order: img[0] is shifted first and ends up in cfg[71].
  logic [31:0] img [72];

  crossbar_switch dut (
    .clk(clk), .nres(nres), .prog_i(prog_i), .prog_shft(prog_shft),
    .prog_o(prog_o), .N_i(N_i), .S_o(S_o), .S_i(S_i), .N_o(N_o),
    .W_i(W_i), .E_o(E_o), .E_i(E_i), .W_o(W_o)
  );

  always #5 clk = ~clk;

  task automatic set_default_inputs();
    N_i = 32'h87654321;
    W_i = 32'h0fedcba9;
    S_i = 16'ha5a5;
    E_i = 16'h5a5a;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nres = 1'b1; prog_shft = 1'b0; prog_i = '0;
    @(posedge clk); #1;
    @(negedge clk);
    nres = 1'b0;
  endtask

  task automatic shift_word(input logic [31:0] w);
    @(negedge clk);
    prog_i = w; prog_shft = 1'b1;
    @(posedge clk); #1;
    prog_shft = 1'b0; prog_i = '0;
  endtask

  task automatic clear_img();
    for (int n = 0; n < 72; n++) img[n] = '0;
  endtask

  task automatic load_img();
    for (int n = 0; n < 72; n++) shift_word(img[n]);
  endtask

  task automatic test_reset();
    set_default_inputs();
    do_reset();
    #1;
    checks++; if (prog_o !== 32'h0) begin fails++; $display("FAIL reset prog_o: got %h required %h", prog_o, 32'h0); end
    checks++; if (E_o !== 32'h0fedcba9) begin fails++; $display("FAIL reset E_o: got %h required %h", E_o, 32'h0fedcba9); end
    checks++; if (W_o !== 16'h5a5a) begin fails++; $display("FAIL reset W_o: got %h required %h", W_o, 16'h5a5a); end
    checks++; if (S_o !== 32'h87654321) begin fails++; $display("FAIL reset S_o: got %h required %h", S_o, 32'h87654321); end
    checks++; if (N_o !== 16'ha5a5) begin fails++; $display("FAIL reset N_o: got %h required %h", N_o, 16'ha5a5); end
  endtask

  task automatic test_ne_identity();
    do_reset();
    clear_img();
    for (int e = 0; e < 32; e++) img[24+e] = 32'h1 << e;
    load_img();
    checks++; if (E_o !== 32'h87654321) begin fails++; $display("FAIL ne_identity E_o: got %h required %h", E_o, 32'h87654321); end
    checks++; if (W_o !== 16'h5a5a) begin fails++; $display("FAIL ne_identity W_o: got %h required %h", W_o, 16'h5a5a); end
    N_i = 32'h0000ffff; #1;
    checks++; if (E_o !== 32'h0000ffff) begin fails++; $display("FAIL ne_identity_n2 E_o: got %h required %h", E_o, 32'h0000ffff); end
    set_default_inputs();
  endtask

  task automatic test_sw_identity();
    do_reset();
    clear_img();
    for (int w = 0; w < 8; w++) img[16+w] = ((32'h1 << (2*w+1)) << 16) | (32'h1 << (2*w));
    load_img();
    checks++; if (W_o !== 16'ha5a5) begin fails++; $display("FAIL sw_identity W_o: got %h required %h", W_o, 16'ha5a5); end
    checks++; if (E_o !== 32'h0fedcba9) begin fails++; $display("FAIL sw_identity E_o: got %h required %h", E_o, 32'h0fedcba9); end
    S_i = 16'h1234; #1;
    checks++; if (W_o !== 16'h1234) begin fails++; $display("FAIL sw_identity_s2 W_o: got %h required %h", W_o, 16'h1234); end
    checks++; if (N_o !== 16'h1234) begin fails++; $display("FAIL sw_identity_s2 N_o: got %h required %h", N_o, 16'h1234); end
    set_default_inputs();
  endtask

  task automatic test_nw_or();
    do_reset();
    clear_img();
    img[56] = 32'hffffffff;
    load_img();
    checks++; if (W_o !== 16'h5a5b) begin fails++; $display("FAIL nw_or W_o: got %h required %h", W_o, 16'h5a5b); end
    N_i = 32'h0; #1;
    checks++; if (W_o !== 16'h5a5a) begin fails++; $display("FAIL nw_or_zero W_o: got %h required %h", W_o, 16'h5a5a); end
    set_default_inputs();
  endtask

  task automatic test_se_last();
    // SE word 15 high half routes S_i[0] onto E_o[31].
    do_reset();
    clear_img();
    img[15] = 32'h0001_0000;
    load_img();
    checks++; if (E_o !== 32'h8fedcba9) begin fails++; $display("FAIL se_last E_o: got %h required %h", E_o, 32'h8fedcba9); end
    S_i = 16'ha5a4; #1;
    checks++; if (E_o !== 32'h0fedcba9) begin fails++; $display("FAIL se_last_zero E_o: got %h required %h", E_o, 32'h0fedcba9); end
    set_default_inputs();
  endtask

  task automatic test_cascade();
    do_reset();
    shift_word(32'hfedcab98);
    for (int n = 0; n < 70; n++) shift_word(32'h0);
    checks++; if (prog_o !== 32'h0) begin fails++; $display("FAIL cascade_71 prog_o: got %h required %h", prog_o, 32'h0); end
    shift_word(32'h0);
    checks++; if (prog_o !== 32'hfedcab98) begin fails++; $display("FAIL cascade_72 prog_o: got %h required %h", prog_o, 32'hfedcab98); end
    // Word now sits in SE word 0, driving E_o[1:0] high.
    checks++; if (E_o !== 32'h0fedcbab) begin fails++; $display("FAIL cascade_72 E_o: got %h required %h", E_o, 32'h0fedcbab); end
    @(negedge clk);
    prog_i = 32'hdeadbeef; prog_shft = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (prog_o !== 32'hfedcab98) begin fails++; $display("FAIL hold_full prog_o: got %h required %h", prog_o, 32'hfedcab98); end
    checks++; if (E_o !== 32'h0fedcbab) begin fails++; $display("FAIL hold_full E_o: got %h required %h", E_o, 32'h0fedcbab); end
    shift_word(32'h0);
    checks++; if (prog_o !== 32'h0) begin fails++; $display("FAIL cascade_73 prog_o: got %h required %h", prog_o, 32'h0); end
    checks++; if (E_o !== 32'h0fedcba9) begin fails++; $display("FAIL cascade_73 E_o: got %h required %h", E_o, 32'h0fedcba9); end
    repeat (10) @(posedge clk);
    #1;
    checks++; if (prog_o !== 32'h0) begin fails++; $display("FAIL hold_empty prog_o: got %h required %h", prog_o, 32'h0); end
    checks++; if (W_o !== 16'h5a5a) begin fails++; $display("FAIL hold_empty W_o: got %h required %h", W_o, 16'h5a5a); end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    for (int n = 0; n < 40; n++) shift_word(32'haaaa5555);
    // cfg[0..39] loaded: NE words 8..31 and all NW words are non-zero.
    checks++; if (E_o !== 32'hffffffa9) begin fails++; $display("FAIL partial E_o: got %h required %h", E_o, 32'hffffffa9); end
    checks++; if (W_o !== 16'hffff) begin fails++; $display("FAIL partial W_o: got %h required %h", W_o, 16'hffff); end
    // Reset together with a shift request: reset must win.
    @(negedge clk);
    nres = 1'b1; prog_shft = 1'b1; prog_i = 32'haaaa5555;
    @(posedge clk); #1;
    checks++; if (prog_o !== 32'h0) begin fails++; $display("FAIL midreset prog_o: got %h required %h", prog_o, 32'h0); end
    checks++; if (E_o !== 32'h0fedcba9) begin fails++; $display("FAIL midreset E_o: got %h required %h", E_o, 32'h0fedcba9); end
    checks++; if (W_o !== 16'h5a5a) begin fails++; $display("FAIL midreset W_o: got %h required %h", W_o, 16'h5a5a); end
    checks++; if (S_o !== 32'h87654321) begin fails++; $display("FAIL midreset S_o: got %h required %h", S_o, 32'h87654321); end
    checks++; if (N_o !== 16'ha5a5) begin fails++; $display("FAIL midreset N_o: got %h required %h", N_o, 16'ha5a5); end
    @(negedge clk);
    nres = 1'b0; prog_shft = 1'b0; prog_i = '0;
  endtask

  initial begin
    nres = 1'b1; prog_shft = 1'b0; prog_i = '0;
    set_default_inputs();
    test_reset();
    test_ne_identity();
    test_sw_identity();
    test_nw_or();
    test_se_last();
    test_cascade();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/crossbar_switch.md
Name: crossbar_switch

Overview:
- Programmable routing crossbar for an eFPGA tile.
- Vertical tracks pass straight through: N_i drives S_o and S_i drives N_o.
- Horizontal outputs E_o and W_o can each be rerouted to OR-combinations of the vertical inputs, using configuration bits held in a 72-word shift chain.
- The chain is loaded through prog_i, shifted by prog_shft, and cascades to the next tile through prog_o.

Parameters:
- none (all widths fixed)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- nres  in  1  synchronous, active-high reset
- prog_i  in  32  configuration word entering the chain
- prog_shft  in  1  shift-enable for the configuration chain
- prog_o  out  32  configuration word leaving the chain (cascade output)
- N_i  in  32  north input tracks
- S_o  out  32  south output tracks
- S_i  in  16  south input tracks
- N_o  out  16  north output tracks
- W_i  in  32  west input tracks
- E_o  out  32  east output tracks
- E_i  in  16  east input tracks
- W_o  out  16  west output tracks

Behaviour:
- Config chain: 72 registers cfg[0..71], each 32 bits.
- On each clk rising edge, if nres=1: all cfg cleared to 0. Reset has priority over shifting.
- Else if prog_shft=1: cfg[0]<=prog_i and cfg[i]<=cfg[i-1] for i=1..71.
- Else: cfg holds its value.
- prog_o = cfg[71] (combinational from the register). A word entered on shift n appears on prog_o after 72 shifts.
- Load order for a full load of 72 consecutive shifts:
  - shifted words 0-15 form the SE block, in cfg[71..56]
  - words 16-23 form the SW block, in cfg[55..48]
  - words 24-55 form the NE block, in cfg[47..16]
  - words 56-71 form the NW block, in cfg[15..0]
- Word k of a block is the k-th word shifted into that block.
- NE block: word e (e=0..31) selects which N_i bits feed E_o[e]. Bit j of the word selects N_i[j].
- SE block: word w (w=0..15) covers two E_o bits.
  - bits[15:0] select S_i bits for E_o[2w]
  - bits[31:16] select S_i bits for E_o[2w+1]
- NW block: word o (o=0..15) selects which N_i bits feed W_o[o].
- SW block: word w (w=0..7) covers two W_o bits.
  - bits[15:0] select S_i bits for W_o[2w]
  - bits[31:16] select S_i bits for W_o[2w+1]
- E_o[e]:
  - if any NE or SE select bit for E_o[e] is set, E_o[e] = OR of (N_i & NE select) and (S_i & SE select)
  - otherwise E_o[e] = W_i[e] (default pass-through)
- W_o[o]:
  - if any NW or SW select bit for W_o[o] is set, W_o[o] = OR of (N_i & NW select) and (S_i & SW select)
  - otherwise W_o[o] = E_i[o]
- S_o = N_i and N_o = S_i at all times, unconfigured.
- All routing outputs are purely combinational from the inputs and cfg; there is no pipeline latency.
- Routing is live: outputs follow cfg during shifting, so intermediate glitches are allowed.
- Reset state: cfg all 0, so prog_o=0, E_o=W_i, W_o=E_i, S_o=N_i, N_o=S_i.
- Reset asserted mid-load clears the partial configuration. The next load restarts from an empty chain.
- Shifting more than 72 words pushes the oldest words out through prog_o. Only the last 72 shifted words are retained.

Test Plan:
- Reset with N_i=0x87654321, W_i=0x0fedcba9, S_i=0xa5a5, E_i=0x5a5a:
  - required: prog_o=0, E_o=0x0fedcba9, W_o=0x5a5a, S_o=0x87654321, N_o=0xa5a5.
- Full NE identity load (72 shifts; NE word e = 1<<e, all other words 0):
  - required: E_o=0x87654321, W_o=0x5a5a.
- SW load where word w = 0x00030000<<... is avoided; use SW word w = (1<<(2w+1))<<16 | (1<<2w), all other words 0:
  - required: W_o=S_i=0xa5a5; E_o remains 0x0fedcba9.
- Single NW word 0 = 0xFFFFFFFF (OR of all N_i bits), all other words 0:
  - required: W_o[0]=1, W_o[15:1]=E_i[15:1], giving W_o=0x5a5b.
- Chain cascade: shift in 0xFEDCAB98 followed by 71 zeros:
  - required: prog_o=0xFEDCAB98 after the 72nd shift.
  - One more shift with prog_i=0: prog_o=0.
  - prog_shft=0 for 10 cycles: prog_o and all outputs hold.
- Reset mid-load: assert nres after 40 shifts of 0xaaaa5555:
  - required: the next edge gives prog_o=0 and all outputs at the pass-through values above.
